// File: rtl/lcd_bus_sequencer.sv
// rtl/lcd_bus_sequencer.sv - HD44780-style LCD bus sequencer with power-up init
// Turns byte transfers into timed RS/DATA/EN bus cycles after running the init ROM.
module lcd_bus_sequencer #(
  parameter int unsigned T_PWRUP_CYC = 750000,
  parameter int unsigned T_SETUP_CYC = 2,
  parameter int unsigned T_EN_CYC    = 25,
  parameter int unsigned T_HOLD_CYC  = 2,
  parameter int unsigned T_CMD_CYC   = 2000,
  parameter int unsigned T_LONG_CYC  = 82000,
  parameter int unsigned CNT_W       = 20
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_valid,
  input  logic       i_rs,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_init_done,
  output logic       o_lcd_on,
  output logic       o_lcd_en,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic [7:0] o_lcd_data
);

  typedef enum logic [2:0] {
    S_PWRUP,
    S_INIT_LOAD,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_WAIT,
    S_IDLE
  } state_t;

  // Terminal timer values: a phase of N cycles ends when the timer reads N-1.
  localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(T_PWRUP_CYC - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(T_SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(T_EN_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(T_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(T_CMD_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(T_LONG_CYC - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [1:0]       idx_q, idx_d;
  logic             init_done_q, init_done_d;
  logic             lcd_on_q, lcd_on_d;
  logic             rs_q, rs_d;
  logic [7:0]       data_q, data_d;

  logic [7:0]       rom_data;
  logic             long_wait;
  logic [CNT_W-1:0] wait_last;

  always_comb begin
    rom_data = 8'h38;
    unique case (idx_q)
      2'd0: rom_data = 8'h38;
      2'd1: rom_data = 8'h0C;
      2'd2: rom_data = 8'h01;
      2'd3: rom_data = 8'h06;
      default: rom_data = 8'h38;
    endcase
  end

  // Clear (0x01) and home (0x02/0x03) need the long execution wait.
  assign long_wait = !rs_q && (data_q[7:2] == 6'd0) && (data_q[1:0] != 2'd0);
  assign wait_last = long_wait ? LONG_LAST : CMD_LAST;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q + CNT_W'(1);
    idx_d       = idx_q;
    init_done_d = init_done_q;
    lcd_on_d    = lcd_on_q;
    rs_d        = rs_q;
    data_d      = data_q;

    unique case (state_q)
      S_PWRUP: begin
        if (timer_q == PWRUP_LAST) begin
          state_d  = S_INIT_LOAD;
          timer_d  = '0;
          lcd_on_d = 1'b1;
        end
      end
      S_INIT_LOAD: begin
        rs_d    = 1'b0;
        data_d  = rom_data;
        state_d = S_SETUP;
        timer_d = '0;
      end
      S_SETUP: begin
        if (timer_q == SETUP_LAST) begin
          state_d = S_PULSE;
          timer_d = '0;
        end
      end
      S_PULSE: begin
        if (timer_q == EN_LAST) begin
          state_d = S_HOLD;
          timer_d = '0;
        end
      end
      S_HOLD: begin
        if (timer_q == HOLD_LAST) begin
          state_d = S_WAIT;
          timer_d = '0;
        end
      end
      S_WAIT: begin
        if (timer_q == wait_last) begin
          timer_d = '0;
          state_d = S_IDLE;
          if (!init_done_q) begin
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              init_done_d = 1'b1;
            end else begin
              state_d = S_INIT_LOAD;
            end
          end
        end
      end
      S_IDLE: begin
        timer_d = '0;
        if (i_valid) begin
          rs_d    = i_rs;
          data_d  = i_data;
          state_d = S_SETUP;
        end
      end
      default: begin
        state_d = S_PWRUP;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= S_PWRUP;
      timer_q     <= '0;
      idx_q       <= 2'd0;
      init_done_q <= 1'b0;
      lcd_on_q    <= 1'b0;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      idx_q       <= idx_d;
      init_done_q <= init_done_d;
      lcd_on_q    <= lcd_on_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
    end
  end

  assign o_ready     = (state_q == S_IDLE);
  assign o_lcd_en    = (state_q == S_PULSE);
  assign o_init_done = init_done_q;
  assign o_lcd_on    = lcd_on_q;
  assign o_lcd_rs    = rs_q;
  assign o_lcd_rw    = 1'b0;
  assign o_lcd_data  = data_q;

endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// tb/tb_lcd_bus_sequencer.sv - directed table-driven bench for lcd_bus_sequencer
module tb_lcd_bus_sequencer;

  localparam int T_PWRUP = 20;
  localparam int T_SETUP = 2;
  localparam int T_EN    = 4;
  localparam int T_HOLD  = 2;
  localparam int T_CMD   = 10;
  localparam int T_LONG  = 30;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic       rs = 1'b0;
  logic [7:0] data = 8'h00;
  logic       ready, init_done, lcd_on, lcd_en, lcd_rs, lcd_rw;
  logic [7:0] lcd_data;

  lcd_bus_sequencer #(
    .T_PWRUP_CYC(T_PWRUP), .T_SETUP_CYC(T_SETUP), .T_EN_CYC(T_EN),
    .T_HOLD_CYC(T_HOLD), .T_CMD_CYC(T_CMD), .T_LONG_CYC(T_LONG), .CNT_W(20)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_valid(valid), .i_rs(rs), .i_data(data),
    .o_ready(ready), .o_init_done(init_done), .o_lcd_on(lcd_on),
    .o_lcd_en(lcd_en), .o_lcd_rs(lcd_rs), .o_lcd_rw(lcd_rw), .o_lcd_data(lcd_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // EN pulse log, sampled mid-cycle
  int       p_rise[$];
  int       p_fall[$];
  logic [7:0] p_data[$];
  logic     p_rs[$];
  logic     en_prev = 1'b0;

  always @(negedge clk) begin
    if (lcd_en && !en_prev) begin
      p_rise.push_back(cyc);
      p_fall.push_back(-1);
      p_data.push_back(lcd_data);
      p_rs.push_back(lcd_rs);
    end
    if (!lcd_en && en_prev && p_fall.size() > 0) p_fall[p_fall.size()-1] = cyc;
    en_prev = lcd_en;
  end

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         ready_off;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sync_mon();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_ready(output int rcyc);
    int n;
    n = 0;
    while (!ready && n < 200) begin
      tick();
      n++;
    end
    chk("ready_timeout", int'(ready), 1);
    rcyc = cyc;
  endtask

  // Releases reset and checks the full power-up/init sequence; optionally pokes i_valid.
  task automatic check_init(input bit poke);
    int base, r0, n, w, done_cyc;
    logic prev_ready;
    base = p_rise.size();
    rs = 1'b1;
    data = 8'hFF;
    tick();
    r0 = cyc;
    rst = 1'b0;
    n = 0;
    while (!lcd_on && n < 100) begin
      if (poke && n == 5) valid = 1'b1;
      tick();
      valid = 1'b0;
      n++;
    end
    chk("lcd_on_rise_cycle", cyc - r0, T_PWRUP);
    n = 0;
    prev_ready = ready;
    while (!init_done && n < 500) begin
      if (poke && (n == 3 || n == 40)) valid = 1'b1;
      prev_ready = ready;
      tick();
      valid = 1'b0;
      n++;
    end
    done_cyc = cyc;
    chk("init_done_timeout", int'(init_done), 1);
    chk("ready_with_init_done", int'(ready), 1);
    chk("ready_low_before_done", int'(prev_ready), 0);
    sync_mon();
    chk("init_pulse_count", p_rise.size() - base, 4);
    if (p_rise.size() - base == 4) begin
      chk("init_first_rise", p_rise[base] - r0, T_PWRUP + 1 + T_SETUP);
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("init_data_%0d", i), int'(p_data[base+i]),
            (i == 0) ? 'h38 : (i == 1) ? 'h0C : (i == 2) ? 'h01 : 'h06);
        chk($sformatf("init_rs_%0d", i), int'(p_rs[base+i]), 0);
        chk($sformatf("init_width_%0d", i), p_fall[base+i] - p_rise[base+i], T_EN);
      end
      for (int i = 0; i < 3; i++) begin
        w = (i == 2) ? T_LONG : T_CMD;
        chk($sformatf("init_gap_%0d", i), p_rise[base+i+1] - p_fall[base+i],
            T_HOLD + w + 1 + T_SETUP);
      end
      chk("init_done_after_last_fall", done_cyc - p_fall[base+3], T_HOLD + T_CMD);
    end
    chk("init_data_kept", int'(lcd_data), 'h06);
  endtask

  initial begin
    int k, k2, rcyc, base, n;

    vecs[0] = '{rs: 1'b1, data: 8'h41, ready_off: T_SETUP + T_EN + T_HOLD + T_CMD};
    vecs[1] = '{rs: 1'b0, data: 8'h02, ready_off: T_SETUP + T_EN + T_HOLD + T_LONG};
    vecs[2] = '{rs: 1'b0, data: 8'h80, ready_off: T_SETUP + T_EN + T_HOLD + T_CMD};
    vecs[3] = '{rs: 1'b0, data: 8'h01, ready_off: T_SETUP + T_EN + T_HOLD + T_LONG};
    vecs[4] = '{rs: 1'b0, data: 8'h03, ready_off: T_SETUP + T_EN + T_HOLD + T_LONG};
    vecs[5] = '{rs: 1'b0, data: 8'h04, ready_off: T_SETUP + T_EN + T_HOLD + T_CMD};
    vecs[6] = '{rs: 1'b1, data: 8'h01, ready_off: T_SETUP + T_EN + T_HOLD + T_CMD};

    rst = 1'b1;
    tick();
    tick();
    chk("rst_ready", int'(ready), 0);
    chk("rst_init_done", int'(init_done), 0);
    chk("rst_lcd_on", int'(lcd_on), 0);
    chk("rst_en", int'(lcd_en), 0);
    chk("rst_rs", int'(lcd_rs), 0);
    chk("rst_rw", int'(lcd_rw), 0);
    chk("rst_data", int'(lcd_data), 0);

    check_init(1'b0);

    foreach (vecs[i]) begin
      base = p_rise.size();
      rs = vecs[i].rs;
      data = vecs[i].data;
      valid = 1'b1;
      tick();
      k = cyc;
      valid = 1'b0;
      data = 8'hA5;
      chk($sformatf("v%0d_data", i), int'(lcd_data), int'(vecs[i].data));
      chk($sformatf("v%0d_rs", i), int'(lcd_rs), int'(vecs[i].rs));
      chk($sformatf("v%0d_busy", i), int'(ready), 0);
      wait_ready(rcyc);
      chk($sformatf("v%0d_ready_off", i), rcyc - k, vecs[i].ready_off);
      sync_mon();
      chk($sformatf("v%0d_pulses", i), p_rise.size() - base, 1);
      if (p_rise.size() - base == 1) begin
        chk($sformatf("v%0d_en_rise", i), p_rise[base] - k, T_SETUP);
        chk($sformatf("v%0d_en_fall", i), p_fall[base] - k, T_SETUP + T_EN);
        chk($sformatf("v%0d_pulse_data", i), int'(p_data[base]), int'(vecs[i].data));
      end
      chk($sformatf("v%0d_data_held", i), int'(lcd_data), int'(vecs[i].data));
    end

    // Back-to-back with i_valid held high
    base = p_rise.size();
    rs = 1'b1;
    data = 8'h41;
    valid = 1'b1;
    tick();
    k = cyc;
    data = 8'h42;
    n = 0;
    while (!ready && n < 200) begin
      tick();
      n++;
    end
    chk("b2b_first_data", int'(p_data.size() > base ? p_data[base] : 8'h00), 'h41);
    tick();
    k2 = cyc;
    valid = 1'b0;
    chk("b2b_accept_cycle", k2 - k, T_SETUP + T_EN + T_HOLD + T_CMD + 1);
    chk("b2b_second_data", int'(lcd_data), 'h42);
    chk("b2b_busy", int'(ready), 0);
    wait_ready(rcyc);
    sync_mon();
    chk("b2b_pulses", p_rise.size() - base, 2);
    if (p_rise.size() - base == 2) begin
      chk("b2b_no_overlap", int'(p_rise[base+1] > p_fall[base]), 1);
      chk("b2b_second_rise", p_rise[base+1] - k2, T_SETUP);
      chk("b2b_second_pulse_data", int'(p_data[base+1]), 'h42);
    end

    // Reset while EN is high
    rs = 1'b1;
    data = 8'h55;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    n = 0;
    while (!lcd_en && n < 20) begin
      tick();
      n++;
    end
    chk("abort_en_seen", int'(lcd_en), 1);
    tick();
    rst = 1'b1;
    tick();
    chk("abort_en", int'(lcd_en), 0);
    chk("abort_ready", int'(ready), 0);
    chk("abort_init_done", int'(init_done), 0);
    chk("abort_lcd_on", int'(lcd_on), 0);
    chk("abort_data", int'(lcd_data), 0);
    sync_mon();

    // Full init rerun, with i_valid pokes during PWRUP and init
    check_init(1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
